// File: rtl/ring_nic_pkg.sv
// Shared constants for the ring NIC: processor register map and packet geometry.
package ring_nic_pkg;

  localparam int unsigned NIC_DATA_W = 64;  // default packet / register width
  localparam int unsigned NIC_ADDR_W = 2;   // default register address width

  // Processor-visible register map
  localparam int unsigned NIC_IN_BUF   = 0;
  localparam int unsigned NIC_IN_STAT  = 1;
  localparam int unsigned NIC_OUT_BUF  = 2;
  localparam int unsigned NIC_OUT_STAT = 3;

  // Virtual-channel bit position for the default width
  localparam int unsigned VC_BIT = NIC_DATA_W - 1;

endpackage

// File: rtl/nic_slot.sv
// One-entry packet slot: data register plus full flag.
// Ports:
//   clk, reset   clock and asynchronous active-low reset
//   i_load       capture i_data and mark full
//   i_clear      mark empty (data is kept, only the flag drops)
//   i_data       data to capture
//   o_data       stored data
//   o_full       slot occupied
module nic_slot #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);

  logic [DATA_W-1:0] r_data;
  logic              r_full;

  // Load wins over clear; callers never assert both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/ring_nic.sv
// Network interface between a processor and the PE port of a ring router node.
// Ports:
//   clk, reset          clock and asynchronous active-low reset
//   addr, d_in, d_out   processor register port (d_out registered, 1-cycle read latency)
//   nic_en, nic_wr_en   access strobe and write select
//   net_so/net_ro/net_do  inject handshake toward the router (pesi/peri/pedi)
//   net_si/net_ri/net_di  eject handshake from the router (peso/pero/pedo)
//   net_polarity        router polarity; a packet is sent only when its vc bit matches
module ring_nic
  import ring_nic_pkg::*;
#(
  parameter int unsigned DATA_W = NIC_DATA_W,
  parameter int unsigned ADDR_W = NIC_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              nic_en,
  input  logic              nic_wr_en,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  input  logic              net_polarity
);

  localparam int unsigned VcBit = DATA_W - 1;

  logic [DATA_W-1:0] w_in_buf;
  logic              w_in_full;
  logic [DATA_W-1:0] w_out_buf;
  logic              w_out_full;
  logic              w_wr;
  logic              w_rd;
  logic              w_recv;
  logic              w_in_clear;
  logic              w_out_load;
  logic [DATA_W-1:0] r_d_out;

  assign w_wr = nic_en & nic_wr_en;
  assign w_rd = nic_en & ~nic_wr_en;

  // Eject side: accept only while empty, so a full slot is never overwritten.
  assign net_ri     = ~w_in_full;
  assign w_recv     = net_si & ~w_in_full;
  // Clearing only when full keeps load and clear mutually exclusive.
  assign w_in_clear = w_rd & (addr == ADDR_W'(NIC_IN_BUF)) & w_in_full;

  // Inject side: a write to a full slot is dropped even if a send empties it this edge.
  assign w_out_load = w_wr & (addr == ADDR_W'(NIC_OUT_BUF)) & ~w_out_full;
  assign net_so     = w_out_full & net_ro & (w_out_buf[VcBit] == net_polarity);
  assign net_do     = w_out_buf;

  nic_slot #(
    .DATA_W (DATA_W)
  ) u_eject_slot (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_recv),
    .i_clear (w_in_clear),
    .i_data  (net_di),
    .o_data  (w_in_buf),
    .o_full  (w_in_full)
  );

  nic_slot #(
    .DATA_W (DATA_W)
  ) u_inject_slot (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_out_load),
    .i_clear (net_so),
    .i_data  (d_in),
    .o_data  (w_out_buf),
    .o_full  (w_out_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_out <= '0;
    end else if (w_rd) begin
      case (addr)
        ADDR_W'(NIC_IN_BUF):   r_d_out <= w_in_buf;
        ADDR_W'(NIC_IN_STAT):  r_d_out <= {{(DATA_W-1){1'b0}}, w_in_full};
        ADDR_W'(NIC_OUT_BUF):  r_d_out <= w_out_buf;
        ADDR_W'(NIC_OUT_STAT): r_d_out <= {{(DATA_W-1){1'b0}}, w_out_full};
        default:               r_d_out <= '0;
      endcase
    end
  end

  assign d_out = r_d_out;

endmodule
